parallel_bus_pollable_ram: RTL and testbench
============================================

Name: parallel_bus_pollable_ram

Overview:
- Slave side of a simple asynchronous-handshake parallel bus, driven by a host such as an RPi GPIO master.
- The host writes an address, then writes or reads one RAM word as TRANSACTIONS_PER_WORD slices, most-significant slice first.
- Backing store is an inferred RAM of 2^WIDTH words, each TRANSACTIONS_PER_WORD*WIDTH bits wide.
- The bus pins go through a 3-state bus entry. Differential clock buffering is outside this block.

Parameters:
- WIDTH, 7, bus width; also the address width.
- TRANSACTIONS_PER_WORD, 2, bus slices per RAM word. Must be >=2.
- LOG2_OF_TRANSACTIONS_PER_WORD, $clog2(TRANSACTIONS_PER_WORD), width of the slice index.
- INIT_COUNTER_BIT, 3, bit of the init counter that ends the post-reset init period.

Ports:
- clock50  in  1  sole clock. All logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- bus  inout  WIDTH  shared data/address bus.
- read  in  1  1=read, 0=write.
- register_select  in  1  0=address, 1=data. Ignored on reads.
- enable  in  1  1=host strobe active.
- ack_valid  out  1  registered acknowledge.
- leds  out  8  status bits.

Behaviour:
- Reset:
  - While reset_n=0, all registers clear: ack_valid=0, address=0, slice registers=0, pre_bus=0, write_strobe=0.
  - Also on reset: init=1, counter=0, both slice indices = TRANSACTIONS_PER_WORD-1, all state flags = 0.
  - RAM contents are not cleared. Its output register clears while init=1.
- Init period:
  - After reset_n rises, the counter increments each cycle.
  - init clears on the edge where counter[INIT_COUNTER_BIT]=1, i.e. 9 cycles with the default.
  - During init the bus is ignored and ack_valid=0.
- ack_valid:
  - Outside init, ack_valid <= enable, so it follows enable one cycle late.
  - It is 0 whenever enable was 0.
- Address phase (enable=1, read=0, register_select=0):
  - address <= bus.
  - Write state and read state go idle; both slice indices return to TRANSACTIONS_PER_WORD-1.
- Write state per slice: captured flag, done flag, index wword.
  - On enable=1, read=1'b0, register_select=1, not done, not captured: write_data[wword] <= bus; captured=1. If wword==0, done=1.
  - On the next cycle, while done and captured: write_strobe pulses for exactly 1 cycle per word, even if enable stays high longer.
  - The RAM write uses address and the concatenated word, with write_data[T-1] in the MS position.
- Read state per slice: captured flag, done flag, index rword.
  - On enable=1, read=1, not done, not captured: pre_bus <= RAM word slice [rword]; captured=1. If rword==0, done=1.
- enable=0 advances state for each of write and read independently:
  - If done: go idle and index = TRANSACTIONS_PER_WORD-1.
  - Else if captured: clear captured and decrement the index.
- Bus driver:
  - The bus is driven with pre_bus whenever read=1; this is combinational on the read input.
  - Otherwise the bus is Hi-Z.
- RAM: simple dual-port, write and read both on clock50.
  - Read is registered: 1-cycle latency from address.
  - Address always precedes data by at least one enable cycle, so no bypass is needed.
- Data strobes without a preceding address phase reuse the last address.
- Extra enable-high cycles on the same strobe are ignored, because the captured flag blocks re-capture.
- An address phase mid-word abandons the partial word; no write occurs.
- leds:
  - [7] ack_valid
  - [6] write_strobe
  - [5] 0
  - [4] ~reset_n
  - [3] register_select
  - [2] read
  - [1] enable
  - [0] init

Optional Feature:
- Macro: AUTO_INCREMENT_EN.
- Defined: address increments by 1, wrapping at 2^WIDTH-1 -> 0, on the cycle after each completed word.
  - For writes this is the cycle after write_strobe.
  - For reads it is on the enable=0 that returns read state to idle.
  - This lets back-to-back words be transferred without new address phases.
- Undefined: address changes only in an address phase.

Test Plan:
- Init: pulse reset_n low, release -> ack_valid=0 and leds[0]=1 for 9 cycles, then leds[0]=0. Bus is Hi-Z with read=0.
- Write (WIDTH=8, T=2): addr 0x4c, data slices 0x2a then 0x12, each enable held 3 cycles with 3-cycle gaps.
  - Required: one write_strobe pulse, RAM[0x4c]=0x2a12, ack_valid trails enable by 1 cycle.
- Further writes: 0x4d<-0x2b34, 0x4e<-0x2c56, 0x4f<-0x2d78.
  - Then read each: address phase, then two read strobes.
  - Bus shows MS then LS slice: 0x2b/0x34, 0x2c/0x56, 0x2d/0x78, 0x2a/0x12.
- Mid-word abort: addr 0x10, one data slice 0xaa, then addr 0x11 -> no write_strobe; RAM[0x10] unchanged.
- Asynchronous reset during a read strobe -> bus released, ack_valid=0 immediately, slice index back to MS.
  - After init, a read of 0x4c still returns 0x2a/0x12.
- AUTO_INCREMENT_EN: addr 0x20, write words 0x0102 and 0x0304 with no second address phase.
  - Required: RAM[0x20]=0x0102, RAM[0x21]=0x0304.
  - addr 0xff write then another write -> second word lands at 0x00.

Source files
------------

// File: rtl/parallel_bus_pollable_ram.sv
// Slave end of an asynchronous-handshake parallel bus that gives a host access to a word-wide RAM, one slice at a time.
// Optional feature macro: AUTO_INCREMENT_EN (address steps by one after each completed word).
module parallel_bus_pollable_ram #(
  parameter int WIDTH                         = 7,
  parameter int TRANSACTIONS_PER_WORD         = 2,
  parameter int LOG2_OF_TRANSACTIONS_PER_WORD = $clog2(TRANSACTIONS_PER_WORD),
  parameter int INIT_COUNTER_BIT              = 3
) (
  input  logic             clock50,
  input  logic             reset_n,
  inout  wire  [WIDTH-1:0] bus,
  input  logic             read,
  input  logic             register_select,
  input  logic             enable,
  output logic             ack_valid,
  output logic [7:0]       leds
);

  localparam int WORD_W = TRANSACTIONS_PER_WORD * WIDTH;
  localparam int DEPTH  = 1 << WIDTH;
  localparam logic [LOG2_OF_TRANSACTIONS_PER_WORD-1:0] LAST_SLICE =
    LOG2_OF_TRANSACTIONS_PER_WORD'(TRANSACTIONS_PER_WORD - 1);

  logic                                     init;
  logic [INIT_COUNTER_BIT:0]                counter;
  logic [WIDTH-1:0]                         address;
  logic [WIDTH-1:0]                         pre_bus;
  logic [WIDTH-1:0]                         write_data [TRANSACTIONS_PER_WORD];
  logic                                     write_strobe;
  logic                                     w_captured, w_done, w_written;
  logic [LOG2_OF_TRANSACTIONS_PER_WORD-1:0] wword;
  logic                                     r_captured, r_done;
  logic [LOG2_OF_TRANSACTIONS_PER_WORD-1:0] rword;
  logic [WORD_W-1:0]                        mem [DEPTH];
  logic [WORD_W-1:0]                        ram_q;
  logic [WORD_W-1:0]                        write_word;
  logic                                     addr_phase, w_take, r_take;

  assign addr_phase = !init && enable && !read && !register_select;
  assign w_take     = !init && enable && !read && register_select && !w_done && !w_captured;
  assign r_take     = !init && enable && read && !r_done && !r_captured;

  always_comb begin
    write_word = '0;
    for (int i = 0; i < TRANSACTIONS_PER_WORD; i++)
      write_word[i*WIDTH +: WIDTH] = write_data[i];
  end

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      init         <= 1'b1;
      counter      <= '0;
      ack_valid    <= 1'b0;
      address      <= '0;
      pre_bus      <= '0;
      write_strobe <= 1'b0;
      for (int i = 0; i < TRANSACTIONS_PER_WORD; i++) write_data[i] <= '0;
      w_captured   <= 1'b0;
      w_done       <= 1'b0;
      w_written    <= 1'b0;
      wword        <= LAST_SLICE;
      r_captured   <= 1'b0;
      r_done       <= 1'b0;
      rword        <= LAST_SLICE;
    end else begin
      write_strobe <= 1'b0;
      if (init) begin
        counter   <= counter + 1'b1;
        ack_valid <= 1'b0;
        if (counter[INIT_COUNTER_BIT]) init <= 1'b0;
      end else begin
        ack_valid <= enable;
        if (addr_phase) begin
          address    <= bus;
          w_captured <= 1'b0;
          w_done     <= 1'b0;
          w_written  <= 1'b0;
          wword      <= LAST_SLICE;
          r_captured <= 1'b0;
          r_done     <= 1'b0;
          rword      <= LAST_SLICE;
        end else begin
          if (w_take) begin
            write_data[wword] <= bus;
            w_captured        <= 1'b1;
            if (wword == '0) w_done <= 1'b1;
          end
          // Fires once per word; a release in the same cycle must still clear w_written.
          if (w_done && w_captured && !w_written) begin
            write_strobe <= 1'b1;
            w_written    <= 1'b1;
          end
          if (!enable) begin
            if (w_done) begin
              w_done     <= 1'b0;
              w_captured <= 1'b0;
              w_written  <= 1'b0;
              wword      <= LAST_SLICE;
            end else if (w_captured) begin
              w_captured <= 1'b0;
              wword      <= wword - 1'b1;
            end
          end

          if (r_take) begin
            pre_bus    <= ram_q[rword*WIDTH +: WIDTH];
            r_captured <= 1'b1;
            if (rword == '0) r_done <= 1'b1;
          end
          if (!enable) begin
            if (r_done) begin
              r_done     <= 1'b0;
              r_captured <= 1'b0;
              rword      <= LAST_SLICE;
            end else if (r_captured) begin
              r_captured <= 1'b0;
              rword      <= rword - 1'b1;
            end
          end
`ifdef AUTO_INCREMENT_EN
          if (write_strobe || (!enable && r_done)) address <= address + 1'b1;
`endif
        end
      end
    end
  end

  // Block RAM: no reset on contents; the registered read port is held at zero during init.
  always_ff @(posedge clock50) begin
    if (write_strobe) mem[address] <= write_word;
    if (init) ram_q <= '0;
    else      ram_q <= mem[address];
  end

  // Released while in reset so a held read line cannot fight the host.
  assign bus = (read && reset_n) ? pre_bus : {WIDTH{1'bz}};

  assign leds = {ack_valid, write_strobe, 1'b0, ~reset_n, register_select, read, enable, init};

endmodule

// File: tb/tb_parallel_bus_pollable_ram.sv
// Directed bench for parallel_bus_pollable_ram with an 8-bit bus and two slices per word.
module tb_parallel_bus_pollable_ram;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         read = 1'b0;
  logic         register_select = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] bus_drv = '0;
  logic         bus_oe = 1'b0;
  wire  [W-1:0] bus;
  logic         ack_valid;
  logic [7:0]   leds;
  int           total = 0;
  int           bad = 0;
  int           strobe_cnt = 0;

  parallel_bus_pollable_ram #(.WIDTH(W), .TRANSACTIONS_PER_WORD(2), .INIT_COUNTER_BIT(3)) dut (
    .clock50(clk), .reset_n(reset_n), .bus(bus), .read(read),
    .register_select(register_select), .enable(enable),
    .ack_valid(ack_valid), .leds(leds)
  );

  assign bus = bus_oe ? bus_drv : {W{1'bz}};

  always #10 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (leds[6]) strobe_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic [W-1:0] a);
    read = 1'b0; register_select = 1'b0; bus_oe = 1'b1; bus_drv = a; enable = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0; bus_oe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic write_slice(input logic [W-1:0] d);
    read = 1'b0; register_select = 1'b1; bus_oe = 1'b1; bus_drv = d; enable = 1'b1;
    #1 check("ack_before", 16'(ack_valid), 16'd0);
    @(negedge clk);
    check("ack_high", 16'(ack_valid), 16'd1);
    repeat (2) @(negedge clk);
    enable = 1'b0; bus_oe = 1'b0;
    @(negedge clk);
    check("ack_low", 16'(ack_valid), 16'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic write_word_noaddr(input logic [15:0] w);
    int s0;
    s0 = strobe_cnt;
    write_slice(w[15:8]);
    write_slice(w[7:0]);
    check("strobe_per_word", 16'(strobe_cnt - s0), 16'd1);
  endtask

  task automatic write_word(input logic [W-1:0] a, input logic [15:0] w);
    addr_phase(a);
    write_word_noaddr(w);
  endtask

  task automatic read_slice(output logic [W-1:0] d);
    read = 1'b1; bus_oe = 1'b0; enable = 1'b1;
    @(negedge clk);
    d = bus;
    repeat (2) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic read_word_noaddr(input string tag, input logic [15:0] w);
    logic [W-1:0] d;
    read_slice(d);
    check({tag, "_ms"}, 16'(d), 16'(w[15:8]));
    read_slice(d);
    check({tag, "_ls"}, 16'(d), 16'(w[7:0]));
    read = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_word(input string tag, input logic [W-1:0] a, input logic [15:0] w);
    addr_phase(a);
    read_word_noaddr(tag, w);
  endtask

  initial begin
    logic [W-1:0] d;
    int s0;

    // reset and init window
    repeat (3) @(negedge clk);
    check("leds_in_reset", 16'(leds), 16'h0011);
    check("ack_in_reset", 16'(ack_valid), 16'd0);
    read = 1'b0; register_select = 1'b1; bus_oe = 1'b1; bus_drv = 8'h55; enable = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      check("init_high", 16'(leds[0]), 16'd1);
      check("ack_in_init", 16'(ack_valid), 16'd0);
      if (i == 8) begin
        enable = 1'b0; bus_oe = 1'b0;
      end
      @(negedge clk);
    end
    #1;
    check("init_low", 16'(leds[0]), 16'd0);
    check("ack_after_init", 16'(ack_valid), 16'd0);
    check("no_strobe_in_init", 16'(strobe_cnt), 16'd0);
    bus_oe = 1'b1; bus_drv = 8'h5a;
    #1 check("bus_released_read0", 16'(bus), 16'h005a);
    bus_oe = 1'b0;
    @(negedge clk);

    // basic writes and read-back, MS slice first
    write_word(8'h4c, 16'h2a12);
    write_word(8'h4d, 16'h2b34);
    write_word(8'h4e, 16'h2c56);
    write_word(8'h4f, 16'h2d78);
    read_word("rd_4d", 8'h4d, 16'h2b34);
    read_word("rd_4e", 8'h4e, 16'h2c56);
    read_word("rd_4f", 8'h4f, 16'h2d78);
    read_word("rd_4c", 8'h4c, 16'h2a12);

    // partial word abandoned by a new address phase
    write_word(8'h10, 16'h5566);
    addr_phase(8'h10);
    s0 = strobe_cnt;
    write_slice(8'haa);
    addr_phase(8'h11);
    repeat (2) @(negedge clk);
    check("abort_no_strobe", 16'(strobe_cnt - s0), 16'd0);
    write_word(8'h11, 16'h7788);
    read_word("rd_10_kept", 8'h10, 16'h5566);
    read_word("rd_11", 8'h11, 16'h7788);

`ifdef AUTO_INCREMENT_EN
    write_word(8'h20, 16'h0102);
    write_word_noaddr(16'h0304);
    read_word("ai_rd_20", 8'h20, 16'h0102);
    read_word_noaddr("ai_rd_21", 16'h0304);
    write_word(8'hff, 16'h0a0b);
    write_word_noaddr(16'h0c0d);
    read_word("ai_rd_ff", 8'hff, 16'h0a0b);
    read_word("ai_rd_00", 8'h00, 16'h0c0d);
`else
    write_word(8'h20, 16'h0102);
    write_word_noaddr(16'h0304);
    read_word("noai_rd_20", 8'h20, 16'h0304);
    read_word_noaddr("noai_rd_20_again", 16'h0304);
`endif

    // asynchronous reset in the middle of the LS read strobe
    write_word(8'h00, 16'h3c4d);
    addr_phase(8'h4c);
    read_slice(d);
    check("pre_reset_ms", 16'(d), 16'h002a);
    read = 1'b1; enable = 1'b1;
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("ack_async_clear", 16'(ack_valid), 16'd0);
    check("leds_reset_bit", 16'(leds[4]), 16'd1);
    bus_oe = 1'b1; bus_drv = 8'h5a;
    #1 check("bus_released_reset", 16'(bus), 16'h005a);
    bus_oe = 1'b0; enable = 1'b0; read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("init_done_again", 16'(leds[0]), 16'd0);
    read_word_noaddr("post_reset_addr0", 16'h3c4d);
    read_word("post_reset_4c", 8'h4c, 16'h2a12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
